// File: rtl/ed_spike_detector.sv
// Spike detector on the ED energy stream: adaptive EMA threshold, peak/timestamp capture, refractory hold-off.
// Latency: last sample of a spike accepted at edge N -> spike_valid high after edge N+1; threshold lags EMA by one cycle.
// Backpressure: none; one sample per in_valid cycle, all state holds while in_valid=0.
// Optional feature macro ED_SPIKE_COUNT_EN adds a saturating 16-bit spike_count output.
module ed_spike_detector #(
  parameter int IN_BITS   = 29,
  parameter int AVG_SH    = 8,
  parameter int THR_MULT  = 8,
  parameter int THR_MIN   = 16,
  parameter int WARMUP    = 256,
  parameter int REFRACT   = 32,
  parameter int MAX_WIDTH = 64,
  parameter int TS_BITS   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_BITS-1:0] energy_in,
  input  logic               in_valid,
  output logic               spike_valid,
  output logic [IN_BITS-1:0] spike_peak,
  output logic [TS_BITS-1:0] spike_ts,
  output logic [IN_BITS-1:0] threshold,
  output logic [1:0]         state
`ifdef ED_SPIKE_COUNT_EN
  ,output logic [15:0]       spike_count
`endif
);

  localparam int ACC_W  = IN_BITS + AVG_SH;
  localparam int PROD_W = IN_BITS + 8;
  localparam int WU_W   = $clog2(WARMUP + 1);
  localparam int WD_W   = $clog2(MAX_WIDTH + 1);
  localparam int RF_W   = $clog2(REFRACT + 2);

  typedef enum logic [1:0] {
    S_WARMUP  = 2'd0,
    S_IDLE    = 2'd1,
    S_ABOVE   = 2'd2,
    S_REFRACT = 2'd3
  } st_t;

  st_t                st_q, st_d;
  logic [ACC_W-1:0]   acc;
  logic [IN_BITS-1:0] avg;
  logic [TS_BITS-1:0] ts;
  logic [WU_W-1:0]    wu_cnt;
  logic [WD_W-1:0]    width_q;
  logic [RF_W-1:0]    rf_cnt;
  logic [IN_BITS-1:0] peak;
  logic [TS_BITS-1:0] peak_ts;
  logic               upd_d;
  logic               rpt_pend;
  logic               above;
  logic               ema_upd, start, track, fin;
  logic [PROD_W-1:0]  prod;
  logic [IN_BITS-1:0] thr_calc;

  assign avg   = acc[ACC_W-1:AVG_SH];
  assign above = energy_in > threshold;
  assign state = st_q;

  // Next-state and per-sample control strobes.
  always_comb begin
    st_d    = st_q;
    ema_upd = 1'b0;
    start   = 1'b0;
    track   = 1'b0;
    fin     = 1'b0;
    if (in_valid) begin
      case (st_q)
        S_WARMUP: begin
          ema_upd = 1'b1;
          if (wu_cnt == WU_W'(WARMUP - 1)) st_d = S_IDLE;
        end
        S_IDLE: begin
          if (above) begin
            start = 1'b1;
            st_d  = S_ABOVE;
          end else begin
            ema_upd = 1'b1;
          end
        end
        S_ABOVE: begin
          if (above) begin
            track = 1'b1;
            if (width_q == WD_W'(MAX_WIDTH - 1)) fin = 1'b1;
          end else begin
            fin = 1'b1;
          end
          if (fin) st_d = (REFRACT == 0) ? S_IDLE : S_REFRACT;
        end
        default: begin
          // Refractory: the sample that takes the counter to zero releases back to IDLE.
          if (rf_cnt <= RF_W'(1)) st_d = S_IDLE;
        end
      endcase
    end
  end

  // Threshold candidate: avg*THR_MULT floored at THR_MIN, saturated to the output width.
  always_comb begin
    thr_calc = '0;
    prod     = PROD_W'(avg) * PROD_W'(THR_MULT);
    if (prod > PROD_W'({IN_BITS{1'b1}}))
      thr_calc = '1;
    else if (prod < PROD_W'(THR_MIN))
      thr_calc = IN_BITS'(THR_MIN);
    else
      thr_calc = prod[IN_BITS-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= S_WARMUP;
    else     st_q <= st_d;
  end

  // EMA, threshold, timestamp and training counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      upd_d     <= 1'b0;
      threshold <= '0;
      ts        <= '0;
      wu_cnt    <= '0;
    end else begin
      upd_d <= ema_upd;
      // avg <= acc, so subtracting first cannot underflow.
      if (ema_upd) acc <= (acc - ACC_W'(avg)) + ACC_W'(energy_in);
      if (upd_d) threshold <= thr_calc;
      if (in_valid) ts <= ts + 1'b1;
      if (in_valid && st_q == S_WARMUP) wu_cnt <= wu_cnt + 1'b1;
    end
  end

  // Peak tracking, spike width and refractory counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak    <= '0;
      peak_ts <= '0;
      width_q <= '0;
      rf_cnt  <= '0;
    end else begin
      if (start) begin
        peak    <= energy_in;
        peak_ts <= ts;
        width_q <= WD_W'(1);
      end else if (track) begin
        // Strictly greater: ties keep the earlier sample's timestamp.
        if (energy_in > peak) begin
          peak    <= energy_in;
          peak_ts <= ts;
        end
        width_q <= width_q + 1'b1;
      end
      if (fin)
        rf_cnt <= RF_W'(REFRACT);
      else if (in_valid && st_q == S_REFRACT && rf_cnt != '0)
        rf_cnt <= rf_cnt - 1'b1;
    end
  end

  // Report stage: one cycle after the terminating sample so a final peak update is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_pend    <= 1'b0;
      spike_valid <= 1'b0;
      spike_peak  <= '0;
      spike_ts    <= '0;
    end else begin
      rpt_pend    <= fin;
      spike_valid <= rpt_pend;
      if (rpt_pend) begin
        spike_peak <= peak;
        spike_ts   <= peak_ts;
      end
    end
  end

`ifdef ED_SPIKE_COUNT_EN
  // Saturating count of issued reports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              spike_count <= '0;
    else if (rpt_pend && spike_count != '1) spike_count <= spike_count + 1'b1;
  end
`endif

endmodule
